// File: rtl/title_display_pkg.sv
// Shared constants and helpers for the title text overlay.
package title_display_pkg;
  localparam int NUM_CHARS = 12;
  localparam int CHAR_W = 9;
  localparam int GLYPH_DIM = 8;
  localparam int BOX_IDX_W = 4;
  localparam logic [CHAR_W-1:0] CHAR_SPACE = 9'h100;

  // Glyphs are packed row 0 in the top byte; bit 7 of a row is the leftmost column.
  function automatic logic [7:0] glyph_row(input logic [63:0] glyph, input logic [2:0] row);
    return glyph[{3'd7 - row, 3'b000} +: 8];
  endfunction
endpackage

// File: rtl/font_rom.sv
// 8x8 lowercase font, asynchronous read; address = glyph index * 8 + row.
module font_rom
  import title_display_pkg::*;
(
  input  logic [CHAR_W-1:0] addr,
  output logic [7:0]        data
);

  logic [63:0] glyph;

  always_comb begin
    glyph = '0;
    case (addr[8:3])
      6'd1:  glyph = 64'h003C_023E_4246_3A00;
      6'd2:  glyph = 64'h4040_5C62_4262_5C00;
      6'd3:  glyph = 64'h003C_4240_4042_3C00;
      6'd4:  glyph = 64'h0202_3A46_4246_3A00;
      6'd5:  glyph = 64'h003C_427E_4042_3C00;
      6'd6:  glyph = 64'h0C12_107C_1010_1000;
      6'd7:  glyph = 64'h003A_4646_3A02_3C00;
      6'd8:  glyph = 64'h8080_BCC2_8282_8200;
      6'd9:  glyph = 64'h1000_3010_1010_3800;
      6'd10: glyph = 64'h0400_0C04_0444_3800;
      6'd11: glyph = 64'h4044_4870_4844_4200;
      6'd12: glyph = 64'h3010_1010_1010_3800;
      6'd13: glyph = 64'h0000_7649_4949_4900;
      6'd14: glyph = 64'h0000_5C62_4242_4200;
      6'd15: glyph = 64'h003C_4242_4242_3C00;
      6'd16: glyph = 64'h7C42_427C_4040_4000;
      6'd17: glyph = 64'h3E42_423E_0202_0200;
      6'd18: glyph = 64'h0000_5C60_4040_4000;
      6'd19: glyph = 64'h003E_403C_0202_7C00;
      6'd20: glyph = 64'h1010_7C10_1012_0C00;
      6'd21: glyph = 64'h0000_4242_4246_3A00;
      6'd22: glyph = 64'h0000_4242_4224_1800;
      6'd23: glyph = 64'h0000_4149_4949_3600;
      6'd24: glyph = 64'h0000_4224_1824_4200;
      6'd25: glyph = 64'h0042_4246_3A02_3C00;
      6'd26: glyph = 64'h007E_0408_1020_7E00;
      default: glyph = '0;
    endcase
    data = glyph_row(glyph, addr[2:0]);
  end

endmodule

// File: rtl/title_display.sv
// Renders a row of 12 scaled 8x8 glyphs; two-stage pipeline, one pixel per clock.
module title_display
  import title_display_pkg::*;
#(
  parameter logic [10:0] X_COORD   = 11'd0,
  parameter logic [9:0]  Y_COORD   = 10'd0,
  parameter logic [7:0]  BOX_WIDTH = 8'd40
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [10:0]       x,
  input  logic [9:0]        y,
  input  logic [CHAR_W-1:0] char1,
  input  logic [CHAR_W-1:0] char2,
  input  logic [CHAR_W-1:0] char3,
  input  logic [CHAR_W-1:0] char4,
  input  logic [CHAR_W-1:0] char5,
  input  logic [CHAR_W-1:0] char6,
  input  logic [CHAR_W-1:0] char7,
  input  logic [CHAR_W-1:0] char8,
  input  logic [CHAR_W-1:0] char9,
  input  logic [CHAR_W-1:0] char10,
  input  logic [CHAR_W-1:0] char11,
  input  logic [CHAR_W-1:0] char12,
  output logic              pixel_on
);

  localparam logic [12:0] X_LEFT     = {2'b00, X_COORD};
  localparam logic [12:0] Y_TOP      = {3'b000, Y_COORD};
  localparam logic [12:0] SCALE      = {5'b00000, BOX_WIDTH} / 13'(GLYPH_DIM);
  localparam logic [12:0] COLS_TOTAL = 13'(NUM_CHARS * GLYPH_DIM);

  logic [CHAR_W-1:0] chars [NUM_CHARS];
  assign chars = '{char1, char2, char3, char4, char5, char6,
                   char7, char8, char9, char10, char11, char12};

  logic [12:0] x_ext, y_ext, dx, dy, col_full, row_full;
  logic        in_box;
  logic [BOX_IDX_W-1:0] box_idx;

  assign x_ext = {2'b00, x};
  assign y_ext = {3'b000, y};
  assign dx    = x_ext - X_LEFT;
  assign dy    = y_ext - Y_TOP;

  // Glyph columns counted across the whole string; since BOX_WIDTH = 8*SCALE,
  // the upper bits are the box index and the low three the column in the box.
  assign col_full = dx / SCALE;
  assign row_full = dy / SCALE;
  assign box_idx  = col_full[6:3];
  assign in_box   = (x_ext >= X_LEFT) && (col_full < COLS_TOTAL) &&
                    (y_ext >= Y_TOP) && (row_full < 13'(GLYPH_DIM));

  logic [NUM_CHARS-1:0] box_hit;
  genvar gi;
  generate
    for (gi = 0; gi < NUM_CHARS; gi++) begin : g_box_hit
      assign box_hit[gi] = in_box && (box_idx == BOX_IDX_W'(gi));
    end
  endgenerate

  logic [CHAR_W-1:0] char_sel;
  always_comb begin
    char_sel = '0;
    for (int i = 0; i < NUM_CHARS; i++) begin
      if (box_hit[i]) char_sel = chars[i];
    end
  end

  logic [CHAR_W-1:0] font_addr_next;
  assign font_addr_next = char_sel + {6'b000000, row_full[2:0]};

  logic [CHAR_W-1:0] font_addr_reg;
  logic [2:0]        col_reg;
  logic              in_box_reg;
  logic [7:0]        font_data;

  font_rom u_font_rom (
    .addr (font_addr_reg),
    .data (font_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      font_addr_reg <= '0;
      col_reg       <= '0;
      in_box_reg    <= 1'b0;
      pixel_on      <= 1'b0;
    end else begin
      font_addr_reg <= font_addr_next;
      col_reg       <= col_full[2:0];
      in_box_reg    <= in_box;
      pixel_on      <= in_box_reg & font_data[3'd7 - col_reg];
    end
  end

endmodule

// File: tb/tb_title_display.sv
// Scoreboard bench for title_display spelling "pink panther" at (88,32), 40px boxes.
module tb_title_display;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [10:0] x;
  logic [9:0]  y;
  logic [8:0]  ch [12];
  logic        pixel_on;

  always #5 clk = ~clk;

  title_display #(
    .X_COORD   (11'd88),
    .Y_COORD   (10'd32),
    .BOX_WIDTH (8'd40)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .x        (x),
    .y        (y),
    .char1    (ch[0]),
    .char2    (ch[1]),
    .char3    (ch[2]),
    .char4    (ch[3]),
    .char5    (ch[4]),
    .char6    (ch[5]),
    .char7    (ch[6]),
    .char8    (ch[7]),
    .char9    (ch[8]),
    .char10   (ch[9]),
    .char11   (ch[10]),
    .char12   (ch[11]),
    .pixel_on (pixel_on)
  );

  typedef struct {
    logic        exp;
    string       name;
    logic [10:0] xv;
    logic [9:0]  yv;
  } vec_t;

  vec_t exp_q [$];
  int   checks = 0;
  int   errors = 0;
  logic stim_valid = 1'b0;
  logic vld_d1 = 1'b0;
  logic vld_d2 = 1'b0;

  // Expected output arrives two edges after a vector is applied.
  always @(posedge clk) begin
    vld_d1 <= stim_valid;
    vld_d2 <= vld_d1;
  end

  always @(negedge clk) begin
    if (vld_d2) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_empty: got pixel_on=%0b, required a queued vector", pixel_on);
      end else begin
        vec_t v;
        v = exp_q.pop_front();
        if (pixel_on !== v.exp) begin
          errors++;
          $display("FAIL %s: x=%0d y=%0d got pixel_on=%0b required %0b",
                   v.name, v.xv, v.yv, pixel_on, v.exp);
        end else begin
          $display("ok   %s: x=%0d y=%0d pixel_on=%0b", v.name, v.xv, v.yv, pixel_on);
        end
      end
    end
  end

  task automatic check(input string name, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got pixel_on=%0b required %0b", name, got, exp);
    end else begin
      $display("ok   %s: pixel_on=%0b", name, got);
    end
  endtask

  task automatic apply(input logic [10:0] xv, input logic [9:0] yv, input logic [8:0] c1,
                       input logic exp, input string name);
    vec_t v;
    @(negedge clk);
    x = xv;
    y = yv;
    ch[0] = c1;
    stim_valid = 1'b1;
    v.exp = exp;
    v.name = name;
    v.xv = xv;
    v.yv = yv;
    exp_q.push_back(v);
  endtask

  localparam logic [8:0] P = 9'h080;
  localparam logic [8:0] E = 9'h028;

  initial begin
    rst_n = 1'b0;
    x = '0;
    y = '0;
    ch = '{9'h080, 9'h048, 9'h070, 9'h058, 9'h100, 9'h080,
           9'h008, 9'h070, 9'h0A0, 9'h040, 9'h028, 9'h090};
    #12;
    check("reset_state", pixel_on, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    apply(11'd106, 10'd32,  P, 1'b1, "p_row0_col3");
    apply(11'd426, 10'd38,  P, 1'b1, "t_row1_col3");
    apply(11'd558, 10'd48,  P, 1'b0, "r_row3_col6_unlit");
    apply(11'd366, 10'd115, P, 1'b0, "below_boxes");
    apply(11'd87,  10'd40,  P, 1'b0, "left_of_boxes");
    apply(11'd568, 10'd40,  P, 1'b0, "right_of_boxes");
    apply(11'd448, 10'd32,  P, 1'b1, "h_box_edge_col0");
    apply(11'd447, 10'd32,  P, 1'b0, "t_col7_before_edge");
    apply(11'd256, 10'd32,  P, 1'b0, "space_box");
    apply(11'd431, 10'd62,  P, 1'b1, "t_row6_col4");
    apply(11'd431, 10'd72,  P, 1'b0, "y_bottom_edge");
    apply(11'd431, 10'd31,  P, 1'b0, "y_above_top");
    apply(11'd143, 10'd32,  P, 1'b1, "i_row0_col3");
    apply(11'd533, 10'd42,  P, 1'b1, "r_row2_col1");
    apply(11'd106, 10'd71,  P, 1'b0, "p_row7_blank");
    apply(11'd106, 10'd37,  P, 1'b0, "char1_p_row1");
    apply(11'd106, 10'd37,  E, 1'b1, "char1_e_row1");
    apply(11'd106, 10'd37,  P, 1'b0, "char1_back_to_p");

    @(negedge clk);
    stim_valid = 1'b0;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending vectors, required 0", exp_q.size());
    end

    // Hold a lit pixel, then pull reset between clock edges.
    x = 11'd106;
    y = 10'd32;
    ch[0] = P;
    repeat (3) @(negedge clk);
    check("pre_reset_lit", pixel_on, 1'b1);
    #2 rst_n = 1'b0;
    #1 check("async_clear_no_edge", pixel_on, 1'b0);
    @(posedge clk);
    #1 check("held_in_reset", pixel_on, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1 check("refill_edge1", pixel_on, 1'b0);
    @(posedge clk);
    #1 check("refill_edge2", pixel_on, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation still running at %0t, required completion", $time);
    $fatal(1, "timeout");
  end

endmodule
